// File: rtl/pmod_ad1_pkg.sv
// Shared definitions for the PMOD AD1 dual-channel ADC reader.
// Holds the frame FSM state type and the frame and sample widths.
// It also holds the helper that turns an unsigned 12-bit reading into a
// signed 16-bit sample.
// No ports.
package pmod_ad1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCLK_LO,
    SCLK_HI,
    DONE
  } state_e;

  localparam int FRAME_BITS   = 16;
  localparam int ADC_BITS     = 12;
  localparam int SAMPLE_W     = 16;
  localparam int OFFSET_SHIFT = 4;

  // Offset-binary to two's complement: flipping the MSB subtracts mid-scale
  // (2048). The 4-bit left shift then scales the 12-bit value into 16 bits.
  function automatic logic [SAMPLE_W-1:0] toSigned(input logic [ADC_BITS-1:0] raw);
    return {~raw[ADC_BITS-1], raw[ADC_BITS-2:0], {OFFSET_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Fixed-rate sample tick source.
// It is shared by the ADC capture side and the DAC output side, so both
// ends run from one rate source.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   en   - level enable; while low the counter is held at 0
//   tick - one-cycle pulse every SAMPLE_PERIOD cycles while en is high
module sample_tick_gen #(
  parameter int SAMPLE_PERIOD = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] count_q;

  // Free-running modulo counter. Dropping en parks it at 0, so a re-enable
  // always gives a full period before the first tick.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tick = en && (count_q == LAST);

endmodule

// File: rtl/pmod_ad1_reader.sv
// PMOD AD1 reader.
// Reads two AD7476A-style 12-bit converters that share one chip select and
// one serial clock, and returns both readings as signed 16-bit samples.
// Ports:
//   clk, rst         - system clock / synchronous active-high reset
//   en               - enables periodic conversions (level)
//   sdata0, sdata1   - serial data from channel 0 / channel 1
//   cs_n             - converter chip select, active low
//   sclk             - converter serial clock, idles high
//   sample0, sample1 - latest signed samples, held between valid pulses
//   valid            - one-cycle strobe when sample0/sample1 update
//   busy             - high while a frame is in progress
module pmod_ad1_reader
  import pmod_ad1_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sdata0,
  input  logic        sdata1,
  output logic        cs_n,
  output logic        sclk,
  output logic [15:0] sample0,
  output logic [15:0] sample1,
  output logic        valid,
  output logic        busy
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("pmod_ad1_reader: CLK_DIV must be at least 2");
  end
  if (SAMPLE_PERIOD < 33 * CLK_DIV + 4) begin : g_bad_period
    $error("pmod_ad1_reader: SAMPLE_PERIOD too short for one frame");
  end

  logic tick;

  sample_tick_gen #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  state_e                state_q;
  logic [DW-1:0]         divCnt_q;
  logic [3:0]            bitCnt_q;
  logic [ADC_BITS-1:0]   shift0_q;
  logic [ADC_BITS-1:0]   shift1_q;
  logic                  csN_q;
  logic                  sclk_q;
  logic [SAMPLE_W-1:0]   sample0_q;
  logic [SAMPLE_W-1:0]   sample1_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  divDone;

  assign divDone = (divCnt_q == DIV_LAST);

  // Frame sequencer.
  // Every phase (SETUP, SCLK_LO, SCLK_HI) lasts CLK_DIV cycles, so one frame
  // keeps cs_n low for 33*CLK_DIV cycles. All outputs are registered and
  // change together with the state. The shift registers are only ADC_BITS
  // wide, so the four leading bits fall off the top by the end of the frame.
  // A tick outside IDLE is dropped rather than queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      divCnt_q  <= '0;
      bitCnt_q  <= '0;
      shift0_q  <= '0;
      shift1_q  <= '0;
      csN_q     <= 1'b1;
      sclk_q    <= 1'b1;
      sample0_q <= '0;
      sample1_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q  <= SETUP;
            csN_q    <= 1'b0;
            busy_q   <= 1'b1;
            sclk_q   <= 1'b1;
            divCnt_q <= '0;
            bitCnt_q <= '0;
          end
        end
        SETUP: begin
          if (divDone) begin
            state_q  <= SCLK_LO;
            sclk_q   <= 1'b0;
            divCnt_q <= '0;
          end else begin
            divCnt_q <= divCnt_q + DW'(1);
          end
        end
        SCLK_LO: begin
          if (divDone) begin
            // This is the edge where sclk rises, so it is the only place
            // the data lines are sampled.
            state_q  <= SCLK_HI;
            sclk_q   <= 1'b1;
            divCnt_q <= '0;
            shift0_q <= {shift0_q[ADC_BITS-2:0], sdata0};
            shift1_q <= {shift1_q[ADC_BITS-2:0], sdata1};
          end else begin
            divCnt_q <= divCnt_q + DW'(1);
          end
        end
        SCLK_HI: begin
          if (divDone) begin
            divCnt_q <= '0;
            if (bitCnt_q == BIT_LAST) begin
              state_q   <= DONE;
              csN_q     <= 1'b1;
              busy_q    <= 1'b0;
              valid_q   <= 1'b1;
              sample0_q <= toSigned(shift0_q);
              sample1_q <= toSigned(shift1_q);
            end else begin
              state_q  <= SCLK_LO;
              sclk_q   <= 1'b0;
              bitCnt_q <= bitCnt_q + 4'd1;
            end
          end else begin
            divCnt_q <= divCnt_q + DW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cs_n    = csN_q;
  assign sclk    = sclk_q;
  assign sample0 = sample0_q;
  assign sample1 = sample1_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_pmod_ad1_reader.sv
// Self-checking bench for pmod_ad1_reader.
// Cycle numbering: the first cycle in which the tick counter sits at 0 with
// en high and rst low is cycle 1. The tick therefore falls in cycle
// SAMPLE_PERIOD, and valid falls in cycle SAMPLE_PERIOD + 33*CLK_DIV + 1.
module tb_pmod_ad1_reader;

  localparam int CD  = 4;
  localparam int SP  = 2000;
  localparam int FCD = 2;
  localparam int FSP = 70;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sdata0 = 1'b0;
  logic        sdata1 = 1'b0;
  logic        csN;
  logic        sclk;
  logic [15:0] sample0;
  logic [15:0] sample1;
  logic        valid;
  logic        busy;

  logic        fRst = 1'b1;
  logic        fEn = 1'b0;
  logic        fSdata0 = 1'b0;
  logic        fSdata1 = 1'b0;
  logic        fCsN;
  logic        fSclk;
  logic [15:0] fSample0;
  logic [15:0] fSample1;
  logic        fValid;
  logic        fBusy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lastValidAt = 0;

  // Clock and a free-running cycle counter used for all timing checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pmod_ad1_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
    .clk(clk), .rst(rst), .en(en), .sdata0(sdata0), .sdata1(sdata1),
    .cs_n(csN), .sclk(sclk), .sample0(sample0), .sample1(sample1),
    .valid(valid), .busy(busy)
  );

  pmod_ad1_reader #(.CLK_DIV(FCD), .SAMPLE_PERIOD(FSP)) dutFast (
    .clk(clk), .rst(fRst), .en(fEn), .sdata0(fSdata0), .sdata1(fSdata1),
    .cs_n(fCsN), .sclk(fSclk), .sample0(fSample0), .sample1(fSample1),
    .valid(fValid), .busy(fBusy)
  );

  // Converter model for the default-rate instance. It latches the next
  // 16-bit frame word when cs_n falls, and presents one bit MSB first on
  // each sclk falling edge, so every sclk rise sees a settled bit.
  logic [15:0] nextWord0 = 16'h0000;
  logic [15:0] nextWord1 = 16'h0000;
  logic [15:0] word0 = 16'h0000;
  logic [15:0] word1 = 16'h0000;
  bit          inFrame = 1'b0;

  always @(csN or negedge sclk) begin
    if (csN !== 1'b0) begin
      inFrame = 1'b0;
    end else if (!inFrame) begin
      inFrame = 1'b1;
      word0 = nextWord0;
      word1 = nextWord1;
    end else begin
      sdata0 = word0[15];
      sdata1 = word1[15];
      word0 = {word0[14:0], 1'b0};
      word1 = {word1[14:0], 1'b0};
    end
  end

  // Same converter model for the fast instance.
  logic [15:0] fNext0 = 16'h0000;
  logic [15:0] fNext1 = 16'h0000;
  logic [15:0] fWord0 = 16'h0000;
  logic [15:0] fWord1 = 16'h0000;
  bit          fInFrame = 1'b0;

  always @(fCsN or negedge fSclk) begin
    if (fCsN !== 1'b0) begin
      fInFrame = 1'b0;
    end else if (!fInFrame) begin
      fInFrame = 1'b1;
      fWord0 = fNext0;
      fWord1 = fNext1;
    end else begin
      fSdata0 = fWord0[15];
      fSdata1 = fWord1[15];
      fWord0 = {fWord0[14:0], 1'b0};
      fWord1 = {fWord1[14:0], 1'b0};
    end
  end

  // Frame observer for the default instance, sampled on the falling edge.
  // It records the cs_n low length and sclk rises of the last frame.
  // It also counts valid pulses and idle or busy protocol violations.
  int   csLowRun = 0;
  int   sclkRiseRun = 0;
  int   lastCsLowLen = 0;
  int   lastSclkRises = 0;
  int   csLowCycles = 0;
  int   validCount = 0;
  int   sclkIdleErr = 0;
  int   busyErr = 0;
  logic prevSclk = 1'b1;

  always @(negedge clk) begin
    if (csN === 1'b0) begin
      csLowRun = csLowRun + 1;
      csLowCycles = csLowCycles + 1;
      if (prevSclk === 1'b0 && sclk === 1'b1) sclkRiseRun = sclkRiseRun + 1;
    end else begin
      if (csLowRun > 0) begin
        lastCsLowLen = csLowRun;
        lastSclkRises = sclkRiseRun;
      end
      csLowRun = 0;
      sclkRiseRun = 0;
      if (rst === 1'b0 && sclk !== 1'b1) sclkIdleErr = sclkIdleErr + 1;
    end
    if (rst === 1'b0 && busy !== ~csN) busyErr = busyErr + 1;
    if (valid === 1'b1) validCount = validCount + 1;
    prevSclk = sclk;
  end

  task automatic wait_valid(input int maxCyc, output int atCyc, output bit seen);
    seen = 1'b0;
    atCyc = -1;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        seen = 1'b1;
        atCyc = cyc;
        break;
      end
    end
    #1;
  endtask

  task automatic wait_cs_fall(input int maxCyc, output int atCyc, output bit seen);
    seen = 1'b0;
    atCyc = -1;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (csN === 1'b0) begin
        seen = 1'b1;
        atCyc = cyc;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    nextWord0 = 16'h0ABC;
    nextWord1 = 16'h0ABC;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (csN !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_cs_n: got %b expected 1", csN);
    end
    checks++;
    if (sclk !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_sclk: got %b expected 1", sclk);
    end
    checks++;
    if ({sample0, sample1} !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_samples: got %h/%h expected 0000/0000", sample0, sample1);
    end
    checks++;
    if ({valid, busy} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_valid_busy: got %b%b expected 00", valid, busy);
    end
  endtask

  task automatic test_first_frame();
    int  startCyc;
    int  at;
    bit  seen;
    @(posedge clk);
    #1 rst = 1'b0;
    startCyc = cyc;
    wait_valid(SP + 200, at, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL first_valid_timeout: got none expected a valid pulse");
    end
    checks++;
    if (at - startCyc + 1 !== SP + 33 * CD + 1) begin
      failures++;
      $display("[TB] FAIL first_valid_cycle: got %0d expected %0d", at - startCyc + 1, SP + 33 * CD + 1);
    end
    checks++;
    if (sample0 !== 16'h2BC0) begin
      failures++;
      $display("[TB] FAIL first_sample0: got %h expected 2bc0", sample0);
    end
    checks++;
    if (sample1 !== 16'h2BC0) begin
      failures++;
      $display("[TB] FAIL first_sample1: got %h expected 2bc0", sample1);
    end
    checks++;
    if (lastCsLowLen !== 132) begin
      failures++;
      $display("[TB] FAIL cs_low_len: got %0d expected 132", lastCsLowLen);
    end
    checks++;
    if (lastSclkRises !== 16) begin
      failures++;
      $display("[TB] FAIL sclk_rises: got %0d expected 16", lastSclkRises);
    end
    lastValidAt = at;
  endtask

  task automatic test_conversion();
    logic [11:0] raw0 [3];
    logic [11:0] raw1 [3];
    logic [15:0] exp0 [3];
    logic [15:0] exp1 [3];
    int  at;
    bit  seen;
    raw0 = '{12'h000, 12'hFFF, 12'h800};
    raw1 = '{12'hFFF, 12'h000, 12'h001};
    exp0 = '{16'h8000, 16'h7FF0, 16'h0000};
    exp1 = '{16'h7FF0, 16'h8000, 16'h8010};
    for (int i = 0; i < 3; i++) begin
      nextWord0 = {4'h0, raw0[i]};
      nextWord1 = {4'h0, raw1[i]};
      wait_valid(SP + 200, at, seen);
      checks++;
      if (!seen || at - lastValidAt !== SP) begin
        failures++;
        $display("[TB] FAIL conv_period_%0d: got %0d expected %0d", i, at - lastValidAt, SP);
      end
      checks++;
      if (sample0 !== exp0[i]) begin
        failures++;
        $display("[TB] FAIL conv_sample0_%0d: got %h expected %h", i, sample0, exp0[i]);
      end
      checks++;
      if (sample1 !== exp1[i]) begin
        failures++;
        $display("[TB] FAIL conv_sample1_%0d: got %h expected %h", i, sample1, exp1[i]);
      end
      lastValidAt = at;
    end
  endtask

  task automatic test_leading_bits();
    int  at;
    bit  seen;
    nextWord0 = 16'hF123;
    nextWord1 = 16'hA123;
    wait_valid(SP + 200, at, seen);
    checks++;
    if (!seen || at - lastValidAt !== SP) begin
      failures++;
      $display("[TB] FAIL lead_period: got %0d expected %0d", at - lastValidAt, SP);
    end
    checks++;
    if (sample0 !== 16'h9230 || sample1 !== 16'h9230) begin
      failures++;
      $display("[TB] FAIL lead_samples: got %h/%h expected 9230/9230", sample0, sample1);
    end
    lastValidAt = at;
  endtask

  task automatic test_en_drop();
    int  at;
    int  startCyc;
    int  csBefore;
    int  vBefore;
    bit  seen;
    nextWord0 = 16'h0456;
    nextWord1 = 16'h0BCD;
    wait_cs_fall(SP + 200, at, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL endrop_cs_timeout: got none expected a cs_n fall");
    end
    repeat (50) @(posedge clk);
    #1 en = 1'b0;
    wait_valid(200, at, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL endrop_valid_timeout: got none expected a valid pulse");
    end
    checks++;
    if (sample0 !== 16'hC560 || sample1 !== 16'h3CD0) begin
      failures++;
      $display("[TB] FAIL endrop_samples: got %h/%h expected c560/3cd0", sample0, sample1);
    end
    csBefore = csLowCycles;
    vBefore = validCount;
    repeat (3 * SP) @(posedge clk);
    #1;
    checks++;
    if (csLowCycles !== csBefore || validCount !== vBefore) begin
      failures++;
      $display("[TB] FAIL endrop_quiet: got %0d cs_n-low cycles and %0d valids expected 0 and 0",
               csLowCycles - csBefore, validCount - vBefore);
    end
    nextWord0 = 16'h07FF;
    nextWord1 = 16'h0801;
    @(posedge clk);
    #1 en = 1'b1;
    startCyc = cyc;
    wait_valid(SP + 200, at, seen);
    checks++;
    if (!seen || at - startCyc + 1 !== SP + 33 * CD + 1) begin
      failures++;
      $display("[TB] FAIL reenable_valid_cycle: got %0d expected %0d", at - startCyc + 1, SP + 33 * CD + 1);
    end
    checks++;
    if (sample0 !== 16'hFFF0 || sample1 !== 16'h0010) begin
      failures++;
      $display("[TB] FAIL reenable_samples: got %h/%h expected fff0/0010", sample0, sample1);
    end
  endtask

  task automatic test_reset_mid_frame();
    int  at;
    int  fallAt;
    int  startCyc;
    int  vBefore;
    bit  seen;
    wait_cs_fall(SP + 200, at, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL rstmid_cs_timeout: got none expected a cs_n fall");
    end
    repeat (60) @(posedge clk);
    #1 rst = 1'b1;
    vBefore = validCount;
    @(posedge clk);
    #1;
    checks++;
    if (csN !== 1'b1 || sclk !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_ctrl: got cs_n=%b sclk=%b busy=%b valid=%b expected 1 1 0 0",
               csN, sclk, busy, valid);
    end
    checks++;
    if (sample0 !== 16'h0000 || sample1 !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL rstmid_samples: got %h/%h expected 0000/0000", sample0, sample1);
    end
    rst = 1'b0;
    startCyc = cyc;
    nextWord0 = 16'h0001;
    nextWord1 = 16'h0FFE;
    wait_cs_fall(SP + 200, fallAt, seen);
    checks++;
    if (!seen || fallAt - startCyc + 1 !== SP + 1) begin
      failures++;
      $display("[TB] FAIL rstmid_restart_cycle: got %0d expected %0d", fallAt - startCyc + 1, SP + 1);
    end
    checks++;
    if (validCount !== vBefore) begin
      failures++;
      $display("[TB] FAIL rstmid_no_valid: got %0d valids expected 0", validCount - vBefore);
    end
    wait_valid(200, at, seen);
    checks++;
    if (!seen || at - fallAt !== 33 * CD) begin
      failures++;
      $display("[TB] FAIL rstmid_valid_latency: got %0d expected %0d", at - fallAt, 33 * CD);
    end
    checks++;
    if (sample0 !== 16'h8010 || sample1 !== 16'h7FE0) begin
      failures++;
      $display("[TB] FAIL rstmid_samples_after: got %h/%h expected 8010/7fe0", sample0, sample1);
    end
  endtask

  task automatic test_fast_params();
    int          startCyc;
    int          lowRun;
    int          lastLow;
    int          low0;
    int          nValid;
    int          v0;
    int          v1;
    logic [15:0] s0a;
    logic [15:0] s1a;
    logic [15:0] s0b;
    logic [15:0] s1b;
    lowRun = 0;
    lastLow = 0;
    low0 = 0;
    nValid = 0;
    v0 = 0;
    v1 = 0;
    s0a = 16'h0;
    s1a = 16'h0;
    s0b = 16'h0;
    s1b = 16'h0;
    fEn = 1'b1;
    fNext0 = 16'h0ABC;
    fNext1 = 16'h0123;
    repeat (2) @(posedge clk);
    #1 fRst = 1'b0;
    startCyc = cyc;
    for (int i = 0; i < 400 && nValid < 2; i++) begin
      @(negedge clk);
      if (fCsN === 1'b0) begin
        lowRun = lowRun + 1;
      end else begin
        if (lowRun > 0) lastLow = lowRun;
        lowRun = 0;
      end
      if (fValid === 1'b1) begin
        if (nValid == 0) begin
          v0 = cyc;
          low0 = lastLow;
          s0a = fSample0;
          s1a = fSample1;
          fNext0 = 16'h0FFF;
          fNext1 = 16'h0000;
        end else begin
          v1 = cyc;
          s0b = fSample0;
          s1b = fSample1;
        end
        nValid = nValid + 1;
      end
    end
    checks++;
    if (nValid !== 2) begin
      failures++;
      $display("[TB] FAIL fast_valid_count: got %0d expected 2", nValid);
    end
    checks++;
    if (v0 - startCyc + 1 !== FSP + 33 * FCD + 1) begin
      failures++;
      $display("[TB] FAIL fast_first_valid: got %0d expected %0d", v0 - startCyc + 1, FSP + 33 * FCD + 1);
    end
    checks++;
    if (low0 !== 66) begin
      failures++;
      $display("[TB] FAIL fast_cs_low_len: got %0d expected 66", low0);
    end
    checks++;
    if (v1 - v0 !== FSP) begin
      failures++;
      $display("[TB] FAIL fast_period: got %0d expected %0d", v1 - v0, FSP);
    end
    checks++;
    if (s0a !== 16'h2BC0 || s1a !== 16'h9230) begin
      failures++;
      $display("[TB] FAIL fast_samples_1: got %h/%h expected 2bc0/9230", s0a, s1a);
    end
    checks++;
    if (s0b !== 16'h7FF0 || s1b !== 16'h8000) begin
      failures++;
      $display("[TB] FAIL fast_samples_2: got %h/%h expected 7ff0/8000", s0b, s1b);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (sclkIdleErr !== 0) begin
      failures++;
      $display("[TB] FAIL sclk_idle_high: got %0d bad cycles expected 0", sclkIdleErr);
    end
    checks++;
    if (busyErr !== 0) begin
      failures++;
      $display("[TB] FAIL busy_tracks_cs: got %0d bad cycles expected 0", busyErr);
    end
  endtask

  // Scenario sequence; each task checks its own results inline.
  initial begin
    $display("[TB] starting pmod_ad1_reader bench");
    test_reset();
    test_first_frame();
    test_conversion();
    test_leading_bits();
    test_en_drop();
    test_reset_mid_frame();
    test_fast_params();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
